instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Supplies the 32-bit Instruction word consumed by the control signal generator; it is the fetch-side producer on that interface.
- Owns the PC, the next-PC selection and the memory read handshake.
- Consumes the generator's IR_Enable, PC_Enable and PC_Select, and returns the Instruction with a one-cycle valid pulse.
- Sits between instruction memory and the control unit in the 5-stage multicycle datapath.

Parameters:
- ADDR_WIDTH, 32, PC and memory address width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- PC_STEP, 4, sequential PC increment.
- MAX_WAIT, 15, maximum Mem_Ready wait cycles before the fetch is aborted.
- NOP_WORD, 32'h0000_0000, instruction word driven at reset and on timeout.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- IR_Enable  in  1  fetch request from the control unit (Fetch stage).
- PC_Enable  in  1  PC update strobe.
- PC_Select  in  2  00 sequential, 01 Branch_Target, 10 Register_Target, 11 hold.
- Branch_Target  in  ADDR_WIDTH  PC-relative target, already computed.
- Register_Target  in  ADDR_WIDTH  jump-register target.
- Mem_Address  out  ADDR_WIDTH  instruction memory address.
- Mem_Read_Req  out  1  read request.
- Mem_Ready  in  1  read data valid.
- Mem_Read_Data  in  32  instruction from memory.
- Instruction  out  32  registered instruction to the control signal generator.
- Instruction_Valid  out  1  one-cycle pulse when Instruction is updated.
- Fetch_Busy  out  1  high in WAIT.
- PC  out  ADDR_WIDTH  current PC.
- PC_Temp  out  ADDR_WIDTH  return address: the new PC + PC_STEP, captured on each applied update.
- Fetch_Timeout  out  1  sticky error flag.

Behaviour:
- Reset values: PC=RESET_PC, PC_Temp=RESET_PC+PC_STEP, Instruction=NOP_WORD, Instruction_Valid=0, Mem_Read_Req=0, Mem_Address=RESET_PC, Fetch_Busy=0, Fetch_Timeout=0, state IDLE, pending buffer empty, wait counter 0.
- State IDLE:
  - Mem_Read_Req=0.
  - On IR_Enable: latch Mem_Address=PC (the pre-update PC), set Mem_Read_Req=1, clear the wait counter, go to WAIT.
  - Mem_Ready in IDLE is ignored.
- State WAIT:
  - Mem_Read_Req and Mem_Address are held stable; Fetch_Busy=1.
  - On Mem_Ready: Instruction<=Mem_Read_Data, pulse Instruction_Valid, drop Mem_Read_Req, go to IDLE.
  - Otherwise the counter increments. On the cycle the counter reaches MAX_WAIT with no Mem_Ready: Instruction<=NOP_WORD, pulse Instruction_Valid, set Fetch_Timeout (held until Reset), drop Mem_Read_Req, go to IDLE.
  - Mem_Ready on that same cycle wins; no timeout is flagged.
- Latency:
  - IR_Enable at cycle n gives Mem_Read_Req=1 from cycle n+1.
  - Mem_Ready at cycle m gives Instruction and Instruction_Valid at cycle m+1.
  - Zero-wait memory (Mem_Ready at n+1) gives a valid instruction at n+2.
- PC update:
  - In IDLE, PC_Enable applies the update on the next edge: PC<=next PC per PC_Select, and PC_Temp<=that next PC + PC_STEP.
  - PC_Select=11 leaves PC and PC_Temp unchanged.
  - IR_Enable and PC_Enable in the same IDLE cycle: the fetch uses the old PC and the PC updates in parallel.
  - PC_Enable during WAIT: PC_Select and the selected target are captured into a one-entry pending buffer and applied on the cycle after WAIT exits.
  - A second PC_Enable while the buffer is full overwrites the buffer (last wins).
  - PC_Enable on the same cycle the pending entry is applied: the new request wins and the pending entry is dropped.
- IR_Enable during WAIT is ignored; it is not queued.
- Arithmetic: PC + PC_STEP wraps modulo 2^ADDR_WIDTH. Targets are used unmodified, with no alignment check.
- Reset asserted mid-WAIT aborts the fetch. A Mem_Ready arriving after Reset deasserts is ignored, because the state is IDLE.

Decomposition:
- Package fetch_pkg holds:
  - the state enum {IDLE, WAIT};
  - PC_Select encodings (PCSEL_SEQ, PCSEL_BRANCH, PCSEL_REG, PCSEL_HOLD);
  - the default NOP_WORD.
- One sub-module, pc_next_unit, holds the PC register, PC_Temp, the next-PC mux and the pending-update buffer. The top level holds the fetch FSM, the wait counter and the Instruction register.

Test Plan:
- Reset, then IR_Enable for 1 cycle with Mem_Ready the following cycle and data 32'h1234_5678 -> Mem_Address=0; Instruction=32'h1234_5678 with a 1-cycle Valid pulse 2 cycles after IR_Enable.
- IR_Enable and PC_Enable with PC_Select=00 in the same cycle at PC=8 -> Mem_Address=8, PC=12, PC_Temp=16.
- PC_Enable with PC_Select=01 and Branch_Target=32'h40 during a 3-cycle wait -> PC stays unchanged until WAIT exits, then PC=32'h40 one cycle later.
- No Mem_Ready for MAX_WAIT=15 cycles -> Instruction=NOP_WORD, Valid pulse, Fetch_Timeout=1 and sticky; the next fetch works normally.
- PC=32'hFFFF_FFFC with a sequential update -> PC=0, PC_Temp=4.
- Reset asserted mid-WAIT, then a late Mem_Ready -> Mem_Read_Req=0 immediately, Instruction remains NOP_WORD, no Valid pulse.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  // Fetch FSM states.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

  // Next-PC source encodings carried on PC_Select.
  typedef enum logic [1:0] {
    PCSEL_SEQ    = 2'b00,
    PCSEL_BRANCH = 2'b01,
    PCSEL_REG    = 2'b10,
    PCSEL_HOLD   = 2'b11
  } pc_sel_t;

  // Instruction word presented after reset and on a fetch timeout.
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/pc_next_unit.sv
// PC register, return-address register, next-PC mux and the one-entry
// pending-update buffer used while a fetch is outstanding.
module pc_next_unit
  import fetch_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
  parameter int unsigned            PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_idle,
  input  logic                  pc_enable,
  input  logic [1:0]            pc_select,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic [ADDR_WIDTH-1:0] register_target,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_temp
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

  pc_sel_t                 req_sel;
  logic [ADDR_WIDTH-1:0]   req_target;
  logic                    pend_valid;
  pc_sel_t                 pend_sel;
  logic [ADDR_WIDTH-1:0]   pend_target;
  logic                    apply_now;
  pc_sel_t                 apply_sel;
  logic [ADDR_WIDTH-1:0]   apply_target;
  logic [ADDR_WIDTH-1:0]   next_pc;
  logic                    pc_update;

  // Pick the update source: a live request in IDLE beats a buffered one.
  always_comb begin
    req_sel      = pc_sel_t'(pc_select);
    req_target   = (req_sel == PCSEL_BRANCH) ? branch_target : register_target;
    apply_now    = 1'b0;
    apply_sel    = req_sel;
    apply_target = req_target;
    if (fetch_idle) begin
      if (pc_enable) begin
        apply_now = 1'b1;
      end else if (pend_valid) begin
        apply_now    = 1'b1;
        apply_sel    = pend_sel;
        apply_target = pend_target;
      end
    end
    case (apply_sel)
      PCSEL_SEQ:    next_pc = pc + STEP;
      PCSEL_BRANCH: next_pc = apply_target;
      PCSEL_REG:    next_pc = apply_target;
      default:      next_pc = pc;
    endcase
    pc_update = apply_now && (apply_sel != PCSEL_HOLD);
  end

  // PC/PC_Temp update and pending buffer capture (last request wins).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      pc_temp     <= RESET_PC + STEP;
      pend_valid  <= 1'b0;
      pend_sel    <= PCSEL_HOLD;
      pend_target <= '0;
    end else begin
      if (pc_update) begin
        pc      <= next_pc;
        pc_temp <= next_pc + STEP;
      end
      if (fetch_idle) begin
        pend_valid <= 1'b0;
      end else if (pc_enable) begin
        pend_valid  <= 1'b1;
        pend_sel    <= req_sel;
        pend_target <= req_target;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: fetch FSM, memory wait counter with timeout,
// and the Instruction register feeding the control signal generator.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
  parameter int unsigned            PC_STEP    = 4,
  parameter int unsigned            MAX_WAIT   = 15,
  parameter logic [31:0]            NOP_WORD   = DEFAULT_NOP_WORD
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  IR_Enable,
  input  logic                  PC_Enable,
  input  logic [1:0]            PC_Select,
  input  logic [ADDR_WIDTH-1:0] Branch_Target,
  input  logic [ADDR_WIDTH-1:0] Register_Target,
  output logic [ADDR_WIDTH-1:0] Mem_Address,
  output logic                  Mem_Read_Req,
  input  logic                  Mem_Ready,
  input  logic [31:0]           Mem_Read_Data,
  output logic [31:0]           Instruction,
  output logic                  Instruction_Valid,
  output logic                  Fetch_Busy,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic [ADDR_WIDTH-1:0] PC_Temp,
  output logic                  Fetch_Timeout
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  fetch_state_t      state, next_state;
  logic              start_fetch;
  logic              take_data;
  logic              take_timeout;
  logic [CNT_W-1:0]  wait_cnt;

  pc_next_unit #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC),
    .PC_STEP    (PC_STEP)
  ) u_pc_next (
    .clk             (Clock),
    .rst             (Reset),
    .fetch_idle      (state == IDLE),
    .pc_enable       (PC_Enable),
    .pc_select       (PC_Select),
    .branch_target   (Branch_Target),
    .register_target (Register_Target),
    .pc              (PC),
    .pc_temp         (PC_Temp)
  );

  // The request is exactly the WAIT state, so reset drops it immediately.
  assign Mem_Read_Req = (state == WAIT);
  assign Fetch_Busy   = (state == WAIT);

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and fetch events; Mem_Ready wins over a same-cycle timeout.
  always_comb begin
    next_state   = state;
    start_fetch  = 1'b0;
    take_data    = 1'b0;
    take_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (IR_Enable) begin
          start_fetch = 1'b1;
          next_state  = WAIT;
        end
      end
      WAIT: begin
        if (Mem_Ready) begin
          take_data  = 1'b1;
          next_state = IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          take_timeout = 1'b1;
          next_state   = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Address latch, wait counter, Instruction register and sticky timeout.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Mem_Address       <= RESET_PC;
      Instruction       <= NOP_WORD;
      Instruction_Valid <= 1'b0;
      Fetch_Timeout     <= 1'b0;
      wait_cnt          <= '0;
    end else begin
      Instruction_Valid <= take_data | take_timeout;
      if (start_fetch) begin
        Mem_Address <= PC;
        wait_cnt    <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (take_data) begin
        Instruction <= Mem_Read_Data;
      end else if (take_timeout) begin
        Instruction   <= NOP_WORD;
        Fetch_Timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_instruction_fetch_unit;

  localparam int unsigned  AW    = 32;
  localparam logic [31:0]  RST_PC = 32'h0000_0000;
  localparam int unsigned  STEP  = 4;
  localparam int unsigned  MAXW  = 15;
  localparam logic [31:0]  NOP   = 32'h0000_0000;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          IR_Enable;
  logic          PC_Enable;
  logic [1:0]    PC_Select;
  logic [AW-1:0] Branch_Target;
  logic [AW-1:0] Register_Target;
  logic [AW-1:0] Mem_Address;
  logic          Mem_Read_Req;
  logic          Mem_Ready;
  logic [31:0]   Mem_Read_Data;
  logic [31:0]   Instruction;
  logic          Instruction_Valid;
  logic          Fetch_Busy;
  logic [AW-1:0] PC;
  logic [AW-1:0] PC_Temp;
  logic          Fetch_Timeout;

  instruction_fetch_unit #(
    .ADDR_WIDTH (AW),
    .RESET_PC   (RST_PC),
    .PC_STEP    (STEP),
    .MAX_WAIT   (MAXW),
    .NOP_WORD   (NOP)
  ) dut (
    .Clock             (Clock),
    .Reset             (Reset),
    .IR_Enable         (IR_Enable),
    .PC_Enable         (PC_Enable),
    .PC_Select         (PC_Select),
    .Branch_Target     (Branch_Target),
    .Register_Target   (Register_Target),
    .Mem_Address       (Mem_Address),
    .Mem_Read_Req      (Mem_Read_Req),
    .Mem_Ready         (Mem_Ready),
    .Mem_Read_Data     (Mem_Read_Data),
    .Instruction       (Instruction),
    .Instruction_Valid (Instruction_Valid),
    .Fetch_Busy        (Fetch_Busy),
    .PC                (PC),
    .PC_Temp           (PC_Temp),
    .Fetch_Timeout     (Fetch_Timeout)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          m_busy;
  int unsigned m_stall;
  logic [31:0] m_pc, m_temp, m_addr, m_instr;
  bit          m_valid, m_to;
  bit          m_pend;
  logic [1:0]  m_psel;
  logic [31:0] m_pbr, m_prg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_stall = 0;
    m_pc    = RST_PC;
    m_temp  = RST_PC + STEP;
    m_addr  = RST_PC;
    m_instr = NOP;
    m_valid = 0;
    m_to    = 0;
    m_pend  = 0;
    m_psel  = 2'b11;
    m_pbr   = '0;
    m_prg   = '0;
  endtask

  task automatic model_apply(input logic [1:0] sel, input logic [31:0] br, input logic [31:0] rg);
    case (sel)
      2'b00:   m_pc = m_pc + STEP;
      2'b01:   m_pc = br;
      2'b10:   m_pc = rg;
      default: return;
    endcase
    m_temp = m_pc + STEP;
  endtask

  // One rising edge of the reference: fetch side first (uses the old PC).
  task automatic model_edge();
    bit was_idle;
    was_idle = !m_busy;
    m_valid  = 0;
    if (was_idle) begin
      if (IR_Enable) begin
        m_addr  = m_pc;
        m_busy  = 1;
        m_stall = 0;
      end
    end else if (Mem_Ready) begin
      m_instr = Mem_Read_Data;
      m_valid = 1;
      m_busy  = 0;
    end else begin
      m_stall++;
      if (m_stall == MAXW) begin
        m_instr = NOP;
        m_valid = 1;
        m_to    = 1;
        m_busy  = 0;
      end
    end
    if (was_idle) begin
      if (PC_Enable) model_apply(PC_Select, Branch_Target, Register_Target);
      else if (m_pend) model_apply(m_psel, m_pbr, m_prg);
      m_pend = 0;
    end else if (PC_Enable) begin
      m_pend = 1;
      m_psel = PC_Select;
      m_pbr  = Branch_Target;
      m_prg  = Register_Target;
    end
  endtask

  task automatic compare_all();
    check("pc",      PC,      m_pc);
    check("pc_temp", PC_Temp, m_temp);
    check("addr",    Mem_Address, m_addr);
    check("req",     32'(Mem_Read_Req), 32'(m_busy));
    check("busy",    32'(Fetch_Busy),   32'(m_busy));
    check("instr",   Instruction, m_instr);
    check("valid",   32'(Instruction_Valid), 32'(m_valid));
    check("timeout", 32'(Fetch_Timeout), 32'(m_to));
  endtask

  task automatic cycle();
    @(posedge Clock);
    if (Reset) model_reset();
    else model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    IR_Enable = 0; PC_Enable = 0; PC_Select = 2'b00;
    Branch_Target = '0; Register_Target = '0;
    Mem_Ready = 0; Mem_Read_Data = '0;
    model_reset();
    repeat (2) cycle();
    Reset = 1'b0;
    check("rst_pc_temp", PC_Temp, 32'h4);
    check("rst_instr", Instruction, NOP);

    // Basic fetch with zero-wait memory.
    IR_Enable = 1; cycle(); IR_Enable = 0;
    check("t1_req", 32'(Mem_Read_Req), 32'd1);
    check("t1_addr", Mem_Address, 32'h0);
    Mem_Ready = 1; Mem_Read_Data = 32'h1234_5678; cycle(); Mem_Ready = 0;
    check("t1_instr", Instruction, 32'h1234_5678);
    check("t1_valid", 32'(Instruction_Valid), 32'd1);
    cycle();
    check("t1_pulse", 32'(Instruction_Valid), 32'd0);

    // Same-cycle fetch and sequential update at PC=8.
    PC_Enable = 1; PC_Select = 2'b10; Register_Target = 32'h8; cycle();
    IR_Enable = 1; PC_Select = 2'b00; cycle();
    IR_Enable = 0; PC_Enable = 0;
    check("t2_addr", Mem_Address, 32'h8);
    check("t2_pc", PC, 32'hC);
    check("t2_temp", PC_Temp, 32'h10);
    Mem_Ready = 1; Mem_Read_Data = 32'h0BAD_F00D; cycle(); Mem_Ready = 0;

    // Branch requested during a three-cycle wait is deferred.
    IR_Enable = 1; cycle(); IR_Enable = 0;
    PC_Enable = 1; PC_Select = 2'b01; Branch_Target = 32'h40; cycle(); PC_Enable = 0;
    check("t3_hold", PC, 32'hC);
    cycle();
    Mem_Ready = 1; Mem_Read_Data = 32'h1111_2222; cycle(); Mem_Ready = 0;
    check("t3_exit_pc", PC, 32'hC);
    check("t3_exit_busy", 32'(Fetch_Busy), 32'd0);
    cycle();
    check("t3_pc", PC, 32'h40);
    check("t3_temp", PC_Temp, 32'h44);

    // Timeout after MAX_WAIT stall cycles, sticky flag, then normal fetch.
    IR_Enable = 1; cycle(); IR_Enable = 0;
    repeat (MAXW - 1) cycle();
    check("t4_still_busy", 32'(Fetch_Busy), 32'd1);
    cycle();
    check("t4_valid", 32'(Instruction_Valid), 32'd1);
    check("t4_instr", Instruction, NOP);
    check("t4_flag", 32'(Fetch_Timeout), 32'd1);
    cycle();
    check("t4_sticky", 32'(Fetch_Timeout), 32'd1);
    IR_Enable = 1; cycle(); IR_Enable = 0;
    check("t4_addr", Mem_Address, 32'h40);
    Mem_Ready = 1; Mem_Read_Data = 32'hCAFE_F00D; cycle(); Mem_Ready = 0;
    check("t4_next_instr", Instruction, 32'hCAFE_F00D);

    // Sequential update wraps at the top of the address space.
    PC_Enable = 1; PC_Select = 2'b10; Register_Target = 32'hFFFF_FFFC; cycle();
    PC_Select = 2'b00; cycle(); PC_Enable = 0;
    check("t5_pc", PC, 32'h0);
    check("t5_temp", PC_Temp, 32'h4);

    // Reset mid-WAIT aborts the fetch; a late Mem_Ready is ignored.
    IR_Enable = 1; cycle(); IR_Enable = 0;
    cycle();
    #2 Reset = 1'b1;
    #1 model_reset();
    check("t6_req_async", 32'(Mem_Read_Req), 32'd0);
    compare_all();
    cycle();
    Reset = 1'b0;
    Mem_Ready = 1; Mem_Read_Data = 32'hDEAD_BEEF; cycle(); Mem_Ready = 0;
    check("t6_instr", Instruction, NOP);
    check("t6_valid", 32'(Instruction_Valid), 32'd0);

    // Randomized traffic, alternating responsive and slow memory phases.
    for (int i = 0; i < 3000; i++) begin
      int unsigned rp;
      rp = (((i / 250) % 2) == 1) ? 3 : 45;
      IR_Enable       = ($urandom_range(0, 99) < 35);
      PC_Enable       = ($urandom_range(0, 99) < 25);
      PC_Select       = 2'($urandom_range(0, 3));
      Branch_Target   = $urandom;
      Register_Target = $urandom;
      Mem_Ready       = ($urandom_range(0, 99) < rp);
      Mem_Read_Data   = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
